// File: rtl/fpu_shared_wb_responder.sv
// ----------------------------------------------------------------------------
// fpu_shared_wb_responder
//
// Responder end of the shared-FPU arbitration handshake. When the arbiter
// raises S_req, the result of the master chosen by Select (0: M1 adder,
// 1: M2 multiplier) is captured together with its source tag. After a LAT-cycle
// modelled write the pair is committed into a DEPTH-entry circular FIFO and a
// single-cycle S_ack is returned. The FIFO drains to writeback via valid/ready.
//
// Ports
//   CLK, RSTn            clock (posedge) / synchronous active-low reset
//   S_req, Select        request and source select from the arbiter
//   M1_data, M2_data     adder / multiplier results
//   S_ack                registered one-cycle completion pulse
//   abort_pulse          registered one-cycle pulse: request withdrawn in BUSY
//   out_valid/out_ready  FIFO head handshake toward writeback
//   out_data, out_src    FIFO head entry (combinational from storage)
//   fifo_count           number of occupied FIFO entries
// ----------------------------------------------------------------------------
module fpu_shared_wb_responder #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       S_req,
  input  logic                       Select,
  input  logic [DW-1:0]              M1_data,
  input  logic [DW-1:0]              M2_data,
  output logic                       S_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic                       out_src,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       abort_pulse
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK, DROP} state_t;

  state_t          state_reg;
  logic [CNTW-1:0] cnt_reg;
  logic [DW-1:0]   cap_data_reg;
  logic            cap_src_reg;

  logic [DW-1:0]   mem_data [DEPTH];
  logic            mem_src  [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic push_w;
  logic pop_w;

  // Commit happens on the last write-latency cycle, only while the request is
  // still asserted. Fullness was already checked when the capture was taken,
  // and only one capture can be in flight, so a push never meets a full FIFO.
  assign push_w = (state_reg == BUSY) && S_req && (cnt_reg == '0);
  assign pop_w  = out_valid && out_ready;

  assign out_valid  = (count_reg != '0);
  assign out_data   = mem_data[rd_ptr_reg];
  assign out_src    = mem_src[rd_ptr_reg];
  assign fifo_count = count_reg;

  // Handshake FSM with registered S_ack / abort_pulse.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cap_data_reg <= '0;
      cap_src_reg  <= 1'b0;
      S_ack        <= 1'b0;
      abort_pulse  <= 1'b0;
    end else begin
      S_ack       <= 1'b0;
      abort_pulse <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Registered (pre-pop) count gates the capture: a pop on this same
          // edge frees the slot only for the next cycle.
          if (S_req && (count_reg < DEPTH_C)) begin
            cap_data_reg <= Select ? M2_data : M1_data;
            cap_src_reg  <= Select;
            cnt_reg      <= CNT_LOAD;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (!S_req) begin
            abort_pulse <= 1'b1;
            state_reg   <= IDLE;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNTW'(1);
          end else begin
            S_ack     <= 1'b1;
            state_reg <= ACK;
          end
        end
        ACK: begin
          state_reg <= DROP;
        end
        DROP: begin
          // The arbiter's registered S_req may still be high right after the
          // ack; wait it out so one request is never acknowledged twice.
          if (!S_req) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy. Power-of-two depth lets pointers wrap
  // naturally.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_w) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_w)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_w, pop_w})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy tracks validity.
  always_ff @(posedge CLK) begin
    if (push_w) begin
      mem_data[wr_ptr_reg] <= cap_data_reg;
      mem_src[wr_ptr_reg]  <= cap_src_reg;
    end
  end

endmodule

// File: tb/tb_fpu_shared_wb_responder.sv
// ----------------------------------------------------------------------------
// tb_fpu_shared_wb_responder
//
// Directed bench for fpu_shared_wb_responder with DW=32, DEPTH=4, LAT=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, away from the active edge.
// ----------------------------------------------------------------------------
module tb_fpu_shared_wb_responder;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        S_req;
  logic        Select;
  logic [31:0] M1_data;
  logic [31:0] M2_data;
  logic        S_ack;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_src;
  logic [2:0]  fifo_count;
  logic        abort_pulse;

  int n_asserts = 0;
  int n_fails   = 0;
  logic [32:0] exp_q [$];

  fpu_shared_wb_responder #(.DW(32), .DEPTH(4), .LAT(2)) dut (
    .CLK(CLK), .RSTn(RSTn), .S_req(S_req), .Select(Select),
    .M1_data(M1_data), .M2_data(M2_data), .S_ack(S_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .fifo_count(fifo_count), .abort_pulse(abort_pulse)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request: raise S_req, wait (bounded) for S_ack, release.
  task automatic do_req(input logic sel, input logic [31:0] d, input string tag);
    int lat;
    lat = 0;
    S_req = 1'b1;
    Select = sel;
    if (sel) M2_data = d; else M1_data = d;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (S_ack === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, 3);
    S_req = 1'b0;
    tick();
    check({tag, "_ack_width"}, {31'd0, S_ack}, 0);
    tick();
    $display("req %s sel=%0d data=%08h latency=%0d count=%0d", tag, sel, d, lat, fifo_count);
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; S_req = 1'b0; Select = 1'b0;
    M1_data = '0; M2_data = '0; out_ready = 1'b0;
    tick(); tick();
    RSTn = 1'b1;
    check("rst_ack",   {31'd0, S_ack}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_count", {29'd0, fifo_count}, 0);
    check("rst_abort", {31'd0, abort_pulse}, 0);
    $display("reset done");

    // Basic request, S_req held two cycles past the ack.
    S_req = 1'b1; Select = 1'b0; M1_data = 32'h3F800000;
    tick(); check("t1_e0_ack", {31'd0, S_ack}, 0);
    tick(); check("t1_e1_ack", {31'd0, S_ack}, 0);
    tick();
    check("t1_ack",   {31'd0, S_ack}, 1);
    check("t1_valid", {31'd0, out_valid}, 1);
    check("t1_data",  out_data, 32'h3F800000);
    check("t1_src",   {31'd0, out_src}, 0);
    check("t1_count", {29'd0, fifo_count}, 1);
    tick(); check("t1_hold1_ack", {31'd0, S_ack}, 0);
    tick(); check("t1_hold2_ack", {31'd0, S_ack}, 0);
    check("t1_hold_count", {29'd0, fifo_count}, 1);
    S_req = 1'b0;
    tick();
    $display("basic request done count=%0d", fifo_count);
    pop1();
    check("t1_pop_count", {29'd0, fifo_count}, 0);

    // Fill with four M2 results, then back-pressure the fifth.
    for (int i = 1; i <= 4; i++) begin
      do_req(1'b1, 32'(i), "fill");
      check("fill_count", {29'd0, fifo_count}, 32'(i));
    end
    S_req = 1'b1; Select = 1'b1; M2_data = 32'd5;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("full_no_ack", {31'd0, S_ack}, 0);
    end
    check("full_count", {29'd0, fifo_count}, 4);
    check("full_head",  out_data, 32'd1);
    $display("full back-pressure held count=%0d", fifo_count);
    pop1();
    check("full_pop_count", {29'd0, fifo_count}, 3);
    begin
      int got;
      got = 0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (S_ack === 1'b1) begin
          got = k;
          break;
        end
      end
      check("fifth_latency", got, 3);
    end
    check("fifth_count", {29'd0, fifo_count}, 4);
    S_req = 1'b0;
    tick(); tick();
    for (int i = 2; i <= 5; i++) begin
      check("drain_data", out_data, 32'(i));
      check("drain_src",  {31'd0, out_src}, 1);
      $display("pop data=%0d src=%0d", out_data, out_src);
      pop1();
    end
    check("drain_count", {29'd0, fifo_count}, 0);

    // Withdraw the request while BUSY.
    S_req = 1'b1; Select = 1'b0; M1_data = 32'hAA;
    tick();
    S_req = 1'b0;
    tick();
    check("abort_pulse", {31'd0, abort_pulse}, 1);
    check("abort_ack",   {31'd0, S_ack}, 0);
    check("abort_count", {29'd0, fifo_count}, 0);
    tick();
    check("abort_once",  {31'd0, abort_pulse}, 0);
    check("abort_ack2",  {31'd0, S_ack}, 0);
    $display("abort done count=%0d", fifo_count);

    // Three entries, then push and pop on the same edge.
    do_req(1'b0, 32'd10, "p10");
    do_req(1'b0, 32'd11, "p11");
    do_req(1'b0, 32'd12, "p12");
    S_req = 1'b1; Select = 1'b0; M1_data = 32'd13;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_ack",   {31'd0, S_ack}, 1);
    check("pp_count", {29'd0, fifo_count}, 3);
    check("pp_head",  out_data, 32'd11);
    S_req = 1'b0;
    tick(); tick();
    $display("push+pop same cycle count=%0d", fifo_count);

    // Ten more pushes with interleaved pops to exercise pointer wrap.
    exp_q.push_back({1'b0, 32'd11});
    exp_q.push_back({1'b0, 32'd12});
    exp_q.push_back({1'b0, 32'd13});
    for (int i = 0; i < 10; i++) begin
      logic [32:0] e;
      do_req(i[0], 32'(100 + i), "wrap");
      exp_q.push_back({i[0], 32'(100 + i)});
      check("wrap_count", {29'd0, fifo_count}, 4);
      e = exp_q.pop_front();
      check("wrap_data", out_data, e[31:0]);
      check("wrap_src",  {31'd0, out_src}, {31'd0, e[32]});
      pop1();
    end
    check("wrap_end_count", {29'd0, fifo_count}, 3);

    // Reset during BUSY with two entries queued.
    pop1();
    check("pre_rst_count", {29'd0, fifo_count}, 2);
    S_req = 1'b1; Select = 1'b1; M2_data = 32'hDEAD;
    tick();
    RSTn = 1'b0;
    tick();
    check("mid_rst_ack",   {31'd0, S_ack}, 0);
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_count", {29'd0, fifo_count}, 0);
    RSTn = 1'b1; S_req = 1'b0;
    tick();
    check("post_rst_ack",  {31'd0, S_ack}, 0);
    $display("mid-operation reset done");
    do_req(1'b1, 32'hC0000000, "post_rst");
    check("post_rst_count", {29'd0, fifo_count}, 1);
    check("post_rst_data",  out_data, 32'hC0000000);
    check("post_rst_src",   {31'd0, out_src}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
